// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int unsigned INSTR_BYTES   = 4;
    localparam int unsigned FETCH_ADDR_W  = 64;
    localparam int unsigned FETCH_INSTR_W = 32;

    typedef enum logic [1:0] {
        FS_RUN,
        FS_HALTED,
        FS_FAULT
    } fetch_state_t;

    // Buffer entry at the default widths; the top re-declares it for its own parameters.
    typedef struct packed {
        logic [FETCH_ADDR_W-1:0]  pc;
        logic [FETCH_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Prefetch FIFO: wrap-around pointers plus occupancy count; flush beats push, pop on empty ignored.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 2,
    parameter type         entry_t   = fetch_entry_t
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   push_i,
    input  entry_t push_data_i,
    input  logic   pop_i,
    input  logic   flush_i,
    output entry_t head_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q, count_d;
    entry_t          mem_q [BUF_DEPTH];

    logic pop_en;
    logic push_en;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PtrW+1)'(BUF_DEPTH));
    assign pop_en  = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot, so a push into a full buffer is fine then.
    assign push_en = push_i & (~full_o | pop_en);
    assign head_o  = mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (push_en && !pop_en) begin
                count_d = count_q + (PtrW+1)'(1);
            end else if (pop_en && !push_en) begin
                count_d = count_q - (PtrW+1)'(1);
            end
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents of empty slots are don't-care, so no reset.
    always_ff @(posedge clk) begin
        if (push_en && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, reads the ROM, fills the prefetch buffer,
// and handles redirect, halt and illegal-address faults.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 64,
    parameter int unsigned       INSTR_W   = 32,
    parameter int unsigned       MEM_SIZE  = 1024,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int unsigned       BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic [ADDR_W-1:0]  imem_address,
    input  logic [INSTR_W-1:0] imem_instruction,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               fault,
    output logic [ADDR_W-1:0]  fault_pc
);

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    // One extra bit so addresses near the top of the space cannot alias back into the ROM.
    function automatic logic legal(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] last;
        last = {1'b0, a} + (ADDR_W+1)'(INSTR_BYTES - 1);
        return (a[1:0] == 2'b00) && (last < (ADDR_W+1)'(MEM_SIZE));
    endfunction

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] fault_pc_q, fault_pc_d;
    logic              fault_q, fault_d;

    logic   push;
    logic   pop;
    logic   flush;
    logic   buf_full;
    logic   buf_empty;
    entry_t head;
    entry_t push_data;

    assign pop       = ~buf_empty & out_ready;
    assign push_data = '{pc: pc_q, instr: imem_instruction};

    // Next PC, state, fault capture and buffer push/flush; redirect outranks everything.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_pc_d = fault_pc_q;
        push       = 1'b0;
        flush      = 1'b0;
        if (redirect_valid) begin
            flush = 1'b1;
            pc_d  = redirect_pc;
            if (legal(redirect_pc)) begin
                state_d = halt ? FS_HALTED : FS_RUN;
            end else begin
                state_d    = FS_FAULT;
                fault_pc_d = redirect_pc;
            end
        end else begin
            case (state_q)
                FS_RUN: begin
                    if (halt) begin
                        state_d = FS_HALTED;
                    end else if (!legal(pc_q)) begin
                        state_d    = FS_FAULT;
                        fault_pc_d = pc_q;
                    end else if (!(buf_full && !pop)) begin
                        push = 1'b1;
                        pc_d = pc_q + ADDR_W'(INSTR_BYTES);
                    end
                end
                FS_HALTED: begin
                    if (!halt) begin
                        state_d = FS_RUN;
                    end
                end
                FS_FAULT: begin
                    state_d = FS_FAULT;
                end
                default: begin
                    state_d = FS_RUN;
                end
            endcase
        end
        fault_d = (state_d == FS_FAULT);
    end

    // State, PC and fault registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= FS_RUN;
            pc_q       <= RESET_PC;
            fault_pc_q <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_pc_q <= fault_pc_d;
            fault_q    <= fault_d;
        end
    end

    fetch_buffer #(
        .BUF_DEPTH(BUF_DEPTH),
        .entry_t  (entry_t)
    ) u_buffer (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_i     (push),
        .push_data_i(push_data),
        .pop_i      (pop),
        .flush_i    (flush),
        .head_o     (head),
        .full_o     (buf_full),
        .empty_o    (buf_empty)
    );

    assign imem_address = pc_q;
    assign out_valid    = ~buf_empty;
    assign out_instr    = head.instr;
    assign out_pc       = head.pc;
    assign fault        = fault_q;
    assign fault_pc     = fault_pc_q;

endmodule
